alu_rmw_sequencer: RTL and testbench

Multi-cycle controller that sequences the shared ALU and the data-memory port for 6502 read-modify-write instructions (INC, DEC, ASL, LSR, ROL, ROR on memory). It accepts one command from decode, reads the operand, drives the ALU for one cycle, performs the 6502 dummy write of the original value, writes the result back, and returns updated flags to the P register. It sits beside the execute stage and owns the ALU operand and op inputs only while a command is in flight.

---
 rtl/alu_rmw_sequencer_if.sv | 40 ++++
 rtl/alu_rmw_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_rmw_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rmw_sequencer_if.sv
// alu_rmw_sequencer_if
// Bundles the two shared resources the read-modify-write sequencer drives:
// the data-memory port and the shared ALU.
//   Memory : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o   (sequencer -> memory)
//            mem_ack_i, mem_rdata_i                         (memory -> sequencer)
//   ALU    : alu_op_o, alu_opd1_o, alu_opd2_o, alu_status_o (sequencer -> ALU)
//            alu_result_i, alu_status_i                     (ALU -> sequencer)
// The master modport belongs to the sequencer. The slave modport belongs to
// the memory/ALU side.
interface alu_rmw_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic              mem_ack_i;
  logic [7:0]        mem_rdata_i;

  logic [4:0]        alu_op_o;
  logic [15:0]       alu_opd1_o;
  logic [15:0]       alu_opd2_o;
  logic [7:0]        alu_status_o;
  logic [15:0]       alu_result_i;
  logic [7:0]        alu_status_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i,
    output alu_op_o, alu_opd1_o, alu_opd2_o, alu_status_o,
    input  alu_result_i, alu_status_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i,
    input  alu_op_o, alu_opd1_o, alu_opd2_o, alu_status_o,
    output alu_result_i, alu_status_i
  );
endinterface

// File: rtl/alu_rmw_sequencer.sv
// alu_rmw_sequencer
// Sequences a 6502 read-modify-write instruction on memory (INC, DEC, ASL,
// LSR, ROL, ROR). The sequence is:
//   1. read the operand,
//   2. run the shared ALU for one cycle,
//   3. perform the 6502 dummy write of the original byte,
//   4. write the result back,
//   5. hand the updated P register to the status register.
// Ports:
//   clk_i, rst_n_i        clock and synchronous active-low reset
//   start_i, op_i,        command from decode; it is accepted only while idle
//   addr_i, status_i
//   busy_o                high from acceptance until the final write ack
//   done_o, status_we_o   one-cycle pulse after the final write; status_o is valid with it
//   status_o              updated P register
//   illegal_o             one-cycle pulse after a start carrying a non-RMW op
//   bus                   memory port and ALU port (master side)
module alu_rmw_sequencer #(
  parameter int         ADDR_W  = 16,
  parameter logic [4:0] ALU_INC = 5'd5,
  parameter logic [4:0] ALU_DEC = 5'd6,
  parameter logic [4:0] ALU_SHL = 5'd7,
  parameter logic [4:0] ALU_SHR = 5'd8,
  parameter logic [4:0] ALU_ROL = 5'd9,
  parameter logic [4:0] ALU_ROR = 5'd10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [4:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        status_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o,
  output logic [7:0]        status_o,
  output logic              status_we_o,
  alu_rmw_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EXEC   = 3'd2,
    S_DWRITE = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        snap_q, snap_d;        // P at acceptance
  logic [7:0]        operand_q, operand_d;  // original memory byte
  logic [7:0]        result_q, result_d;    // ALU result byte
  logic [7:0]        newp_q, newp_d;        // merged P, published on done
  logic [7:0]        status_q, status_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

  logic              op_legal;
  logic              keep_c;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [15:0]       alu_opd1;
  logic [7:0]        alu_status;

  // The ALU upper result byte and its copy of V/B/D/I/bit5 are not used.
  // The RMW arithmetic stays 8-bit, and those P bits come from the snapshot.
  logic              unused_alu_bits;
  assign unused_alu_bits = ^{bus.alu_result_i[15:8], bus.alu_status_i[6:2]};

  assign op_legal = op_i inside {ALU_INC, ALU_DEC, ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR};

  // INC/DEC do not touch carry on a 6502, whatever the ALU reports for C.
  assign keep_c = (op_q == ALU_INC) || (op_q == ALU_DEC);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      snap_q    <= '0;
      operand_q <= '0;
      result_q  <= '0;
      newp_q    <= '0;
      status_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      snap_q    <= snap_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      newp_q    <= newp_d;
      status_q  <= status_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    snap_d     = snap_q;
    operand_d  = operand_q;
    result_d   = result_q;
    newp_d     = newp_q;
    status_d   = status_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    alu_opd1   = 16'h0000;
    alu_status = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_legal) begin
            op_d    = op_i;
            addr_d  = addr_i;
            snap_d  = status_i;
            state_d = S_READ;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (bus.mem_ack_i) begin
          operand_d = bus.mem_rdata_i;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_opd1   = {8'h00, operand_q};
        alu_status = snap_q;
        result_d   = bus.alu_result_i[7:0];
        newp_d     = {bus.alu_status_i[7], snap_q[6:2], bus.alu_status_i[1],
                      keep_c ? snap_q[0] : bus.alu_status_i[0]};
        state_d    = S_DWRITE;
      end

      // The 6502 dummy write: store the unmodified byte first.
      S_DWRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = operand_q;
        if (bus.mem_ack_i) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = result_q;
        if (bus.mem_ack_i) begin
          status_d = newp_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign status_we_o = done_q;
  assign status_o    = status_q;
  assign illegal_o   = illegal_q;

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.alu_op_o     = op_q;
  assign bus.alu_opd1_o   = alu_opd1;
  assign bus.alu_opd2_o   = 16'h0000;
  assign bus.alu_status_o = alu_status;

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
module tb_alu_rmw_sequencer;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_INC = 5'd5;
  localparam logic [4:0] ALU_DEC = 5'd6;
  localparam logic [4:0] ALU_SHL = 5'd7;
  localparam logic [4:0] ALU_SHR = 5'd8;
  localparam logic [4:0] ALU_ROL = 5'd9;
  localparam logic [4:0] ALU_ROR = 5'd10;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  orig;
    logic [7:0]  res;
    logic [7:0]  newp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  op;
  logic [15:0] addr;
  logic [7:0]  status_in;
  logic        busy, done, illegal, status_we;
  logic [7:0]  status_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  int          waits = 0;
  int          wcnt = 0;
  logic [7:0]  mem_val = 8'h00;

  exp_t         exp_q[$];
  logic [24:0]  txq[$];   // {we, addr, data} per acked memory transaction

  logic         hold_v = 1'b0;
  logic [24:0]  hold_val = '0;

  alu_rmw_sequencer_if #(.ADDR_W(16)) bus ();

  alu_rmw_sequencer #(
    .ADDR_W (16),
    .ALU_INC(ALU_INC), .ALU_DEC(ALU_DEC), .ALU_SHL(ALU_SHL),
    .ALU_SHR(ALU_SHR), .ALU_ROL(ALU_ROL), .ALU_ROR(ALU_ROR)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .op_i       (op),
    .addr_i     (addr),
    .status_i   (status_in),
    .busy_o     (busy),
    .done_o     (done),
    .illegal_o  (illegal),
    .status_o   (status_out),
    .status_we_o(status_we),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference 6502 RMW semantics: returns {result, new P}.
  function automatic logic [15:0] ref_rmw(input logic [4:0] o, input logic [7:0] d,
                                          input logic [7:0] p);
    logic [7:0] r;
    logic       c;
    r = 8'h00;
    c = p[0];
    case (o)
      ALU_INC: r = d + 8'd1;
      ALU_DEC: r = d - 8'd1;
      ALU_SHL: begin r = {d[6:0], 1'b0}; c = d[7]; end
      ALU_SHR: begin r = {1'b0, d[7:1]}; c = d[0]; end
      ALU_ROL: begin r = {d[6:0], p[0]}; c = d[7]; end
      ALU_ROR: begin r = {p[0], d[7:1]}; c = d[0]; end
      default: r = 8'h00;
    endcase
    return {r, r[7], p[6:2], (r == 8'h00), c};
  endfunction

  // ALU model. It reports a raw carry for INC/DEC and junk in the upper
  // result byte and in V/B/D/I/bit5, so the sequencer has to filter them.
  always_comb begin
    logic [7:0] a;
    logic [7:0] r;
    logic       c;
    a = bus.alu_opd1_o[7:0];
    r = 8'h00;
    c = 1'b0;
    case (bus.alu_op_o)
      ALU_INC: begin r = a + 8'd1; c = (a == 8'hFF); end
      ALU_DEC: begin r = a - 8'd1; c = (a != 8'h00); end
      ALU_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      ALU_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      ALU_ROL: begin r = {a[6:0], bus.alu_status_o[0]}; c = a[7]; end
      ALU_ROR: begin r = {bus.alu_status_o[0], a[7:1]}; c = a[0]; end
      default: begin r = 8'h00; c = 1'b0; end
    endcase
    bus.alu_result_i = {8'hA5, r};
    bus.alu_status_i = {r[7], ~bus.alu_status_o[6:2], (r == 8'h00), c};
  end

  // Memory model with a programmable number of wait cycles per access.
  always_comb begin
    bus.mem_ack_i   = bus.mem_req_o && (wcnt >= waits);
    bus.mem_rdata_i = bus.mem_ack_i ? mem_val : 8'hEE;
  end

  always @(posedge clk) begin
    if (bus.mem_req_o && !bus.mem_ack_i) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
    if (bus.mem_ack_i)
      txq.push_back({bus.mem_we_o, bus.mem_addr_o,
                     bus.mem_we_o ? bus.mem_wdata_o : bus.mem_rdata_i});
    hold_v   <= bus.mem_req_o && !bus.mem_ack_i;
    hold_val <= {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
  end

  // Request fields must not move while the request waits for its ack.
  always @(negedge clk) begin
    if (hold_v && bus.mem_req_o)
      chk("req_stable", {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, hold_val);
  end

  // Scoreboard: every done pulse retires one expected command.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("status_we", status_we, 1'b1);
        chk("status_o", status_out, e.newp);
        chk("txn_count", txq.size(), 3);
        if (txq.size() >= 3) begin
          chk("read_txn",   txq.pop_front(), {1'b0, e.addr, e.orig});
          chk("dwrite_txn", txq.pop_front(), {1'b1, e.addr, e.orig});
          chk("write_txn",  txq.pop_front(), {1'b1, e.addr, e.res});
        end
        $display("[TB] cmd addr=%04h orig=%02h res=%02h P=%02h", e.addr, e.orig, e.res, status_out);
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [15:0] a, input logic [7:0] p,
                       input logic [7:0] v, input bit legal);
    exp_t       e;
    logic [15:0] rp;
    op = o; addr = a; status_in = p; mem_val = v; start = 1'b1;
    if (legal) begin
      rp = ref_rmw(o, v, p);
      e.addr = a; e.orig = v; e.res = rp[15:8]; e.newp = rp[7:0];
      exp_q.push_back(e);
    end
  endtask

  // Called just after the accepting edge; k is the cycle index of done (T+k).
  task automatic run_and_time(input string tag, output int k);
    @(negedge clk);
    k = 1;
    chk({tag, "_busy_t1"}, busy, 1'b1);
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_busy_in_done"}, busy, 1'b0);
  endtask

  function automatic logic [127:0] all_outs();
    return {busy, done, illegal, status_we, status_out, bus.mem_req_o, bus.mem_we_o,
            bus.mem_addr_o, bus.mem_wdata_o, bus.alu_op_o, bus.alu_opd1_o,
            bus.alu_opd2_o, bus.alu_status_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int dc;
    rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; status_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // INC 7F at 0200, P=01, zero-wait
    waits = 0;
    @(negedge clk);
    issue(ALU_INC, 16'h0200, 8'h01, 8'h7F, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("inc", k);
    chk("inc_latency", k, 5);
    chk("inc_status", status_out, 8'h81);

    // ASL 80 at 0010, P=00
    @(negedge clk);
    issue(ALU_SHL, 16'h0010, 8'h00, 8'h80, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("asl", k);
    chk("asl_status", status_out, 8'h03);

    // ROR 01, P.C=1, three wait cycles per access
    waits = 3;
    @(negedge clk);
    issue(ALU_ROR, 16'h1234, 8'h01, 8'h01, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("ror", k);
    chk("ror_latency", k, 14);
    chk("ror_status", status_out, 8'h81);
    waits = 0;

    // 8-bit boundaries and the remaining ops
    @(negedge clk);
    issue(ALU_INC, 16'h0021, 8'h00, 8'hFF, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("inc_ff", k);
    chk("inc_ff_status", status_out, 8'h02);

    @(negedge clk);
    issue(ALU_DEC, 16'h0022, 8'h41, 8'h00, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("dec_00", k);
    chk("dec_00_status", status_out, 8'hC1);

    @(negedge clk);
    issue(ALU_SHR, 16'h0023, 8'hFF, 8'h01, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("lsr", k);

    @(negedge clk);
    issue(ALU_ROL, 16'h0024, 8'h00, 8'h80, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("rol", k);

    // Illegal op
    @(negedge clk);
    issue(ALU_ADD, 16'h0030, 8'h00, 8'h12, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("illegal_t1", {illegal, busy, bus.mem_req_o, status_we}, 4'b1000);
    @(negedge clk);
    chk("illegal_t2", {illegal, busy, bus.mem_req_o, status_we}, 4'b0000);

    // Reset during the dummy write
    waits = 3;
    dc = done_cnt;
    @(negedge clk);
    issue(ALU_INC, 16'h0300, 8'h00, 8'h55, 1);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req_o && bus.mem_we_o) && n < 50);
    chk("dwrite_reached", bus.mem_req_o && bus.mem_we_o, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_outs", all_outs(), '0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_done", done_cnt, dc);
    chk("midreset_txns", txq.size(), 1);
    if (txq.size() > 0) chk("midreset_read_only", txq[0][24], 1'b0);
    txq.delete();
    waits = 0;

    // Back-to-back DEC, second start in the first done cycle, start held after
    @(negedge clk);
    issue(ALU_DEC, 16'h0400, 8'h00, 8'h10, 1);
    @(posedge clk); #1 start = 1'b0;
    run_and_time("b2b_1", k);
    issue(ALU_DEC, 16'h0401, 8'h80, 8'h01, 1);
    @(posedge clk); #1;
    addr = 16'h0500;   // held start with new fields must be ignored while busy
    fork
      begin
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
      end
    join_none
    run_and_time("b2b_2", k);
    chk("b2b_latency", k, 5);
    chk("b2b_status", status_out, 8'h02);

    repeat (8) @(negedge clk);
    chk("idle_after", busy, 1'b0);
    chk("exp_empty", exp_q.size(), 0);
    chk("txq_empty", txq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
